// File: rtl/bcd_disp_scan.sv
// ---------------------------------------------------------------------------
// bcd_disp_scan
//   Time-multiplexed 4-digit seven-segment driver. Lights one digit at a time
//   from a free-running refresh counter, shows hex values 0-F, and supports
//   leading-zero blanking and whole-display blink. The digit inputs are
//   snapshotted once per frame, so a value that changes mid-frame never tears.
//
// Parameters
//   N        refresh counter width; each digit is lit for 2^(N-2) cycles
//   BLINK_W  frame counter width; blink period is 2^BLINK_W frames
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   synchronous active-high reset
//   d3..d0    in   digit values (d3 most significant)
//   dp_in     in   decimal-point request per digit (bit i = digit i)
//   blank_lz  in   blank leading zeros on digits 3..1
//   blink     in   flash the whole display
//   an        out  anode enables, active low (an[i] = digit i)
//   sseg      out  segments, active low {dp,g,f,e,d,c,b,a}
//   frame     out  one-cycle pulse on the last cycle of each frame
// ---------------------------------------------------------------------------
module bcd_disp_scan #(
    parameter int N       = 18,
    parameter int BLINK_W = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] d3,
    input  logic [3:0] d2,
    input  logic [3:0] d1,
    input  logic [3:0] d0,
    input  logic [3:0] dp_in,
    input  logic       blank_lz,
    input  logic       blink,
    output logic [3:0] an,
    output logic [7:0] sseg,
    output logic       frame
);

    logic [N-1:0]       q_q;
    logic [BLINK_W-1:0] blink_cnt_q;
    logic [15:0]        shadow_q;     // digit i lives at [4*i +: 4]
    logic [3:0]         shadow_dp_q;
    logic [3:0]         an_q;
    logic [7:0]         sseg_q;
    logic               frame_q;

    logic [3:0]         an_d;
    logic [7:0]         sseg_d;
    logic               frame_d;

    logic [1:0]         sel;
    logic               wrap;
    logic [3:0]         digit_cur;
    logic [6:0]         seg7;
    logic [3:0]         lz_blank;
    logic               dark;

    assign sel       = q_q[N-1:N-2];
    assign wrap      = (q_q == {N{1'b1}});
    assign digit_cur = shadow_q[{sel, 2'b00} +: 4];

    // A digit is a leading zero when it and every more significant digit
    // are zero. Digit 0 always shows, so a value of 0 still displays "0".
    assign lz_blank[0] = 1'b0;
    genvar gi;
    generate
        for (gi = 1; gi < 4; gi++) begin : g_lz
            assign lz_blank[gi] = blank_lz && (shadow_q[15:4*gi] == '0);
        end
    endgenerate

    always_comb begin
        seg7 = 7'b1111111;
        case (digit_cur)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            4'hF: seg7 = 7'b0001110;
            default: seg7 = 7'b1111111;
        endcase
    end

    always_comb begin
        dark    = lz_blank[sel] || (blink && blink_cnt_q[BLINK_W-1]);
        an_d    = dark ? 4'b1111 : ~(4'b0001 << sel);
        sseg_d  = dark ? 8'hFF : {~shadow_dp_q[sel], seg7};
        // Registered pulse lands on the cycle where the counter sits at its
        // terminal value, i.e. the same cycle as the snapshot edge.
        frame_d = (q_q == {{(N-1){1'b1}}, 1'b0});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q         <= '0;
            blink_cnt_q <= '0;
            shadow_q    <= '0;
            shadow_dp_q <= '0;
            an_q        <= 4'b1111;
            sseg_q      <= 8'hFF;
            frame_q     <= 1'b0;
        end else begin
            q_q     <= q_q + 1'b1;
            an_q    <= an_d;
            sseg_q  <= sseg_d;
            frame_q <= frame_d;
            if (wrap) begin
                shadow_q    <= {d3, d2, d1, d0};
                shadow_dp_q <= dp_in;
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end
        end
    end

    assign an    = an_q;
    assign sseg  = sseg_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_bcd_disp_scan.sv
// ---------------------------------------------------------------------------
// tb_bcd_disp_scan
//   Directed bench for bcd_disp_scan with N=4 (16-cycle frame, 4-cycle slots)
//   and BLINK_W=2. A vector table covers the decode/blanking/dp paths; hand
//   sequences cover reset, snapshot timing, frame pulse and blink.
//   cyc counts rising edges since the last reset release; the output seen
//   after edge cyc reflects counter value (cyc-1) mod 16.
// ---------------------------------------------------------------------------
module tb_bcd_disp_scan;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] d3, d2, d1, d0, dp_in;
    logic       blank_lz, blink;
    logic [3:0] an;
    logic [7:0] sseg;
    logic       frame;

    int cyc = 0;
    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    bcd_disp_scan #(.N(4), .BLINK_W(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .d3       (d3),
        .d2       (d2),
        .d1       (d1),
        .d0       (d0),
        .dp_in    (dp_in),
        .blank_lz (blank_lz),
        .blink    (blink),
        .an       (an),
        .sseg     (sseg),
        .frame    (frame)
    );

    typedef struct packed {
        logic [3:0]  d3, d2, d1, d0, dp;
        logic        lz;
        logic [15:0] an_exp;   // {slot3, slot2, slot1, slot0}
        logic [31:0] sg_exp;   // {slot3, slot2, slot1, slot0}
    } vec_t;

    vec_t vecs [6];

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // Advance to the edge where the snapshot has just been taken.
    task automatic sync_frame();
        step(1);
        while (cyc % 16 != 0) step(1);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s cyc=%0d got=%02h expected=%02h", name, cyc, act, exp);
    endtask

    task automatic set_digits(input logic [3:0] a3, input logic [3:0] a2,
                              input logic [3:0] a1, input logic [3:0] a0);
        d3 = a3; d2 = a2; d1 = a1; d0 = a0;
    endtask

    initial begin
        logic [7:0] exp_an;
        logic [7:0] exp_sg;
        string nm;

        vecs[0] = '{d3:4'h1, d2:4'h2, d1:4'h3, d0:4'h4, dp:4'b0000, lz:1'b0,
                    an_exp:16'h7BDE, sg_exp:32'hF9A4B099};
        vecs[1] = '{d3:4'h0, d2:4'h0, d1:4'h0, d0:4'h7, dp:4'b0000, lz:1'b1,
                    an_exp:16'hFFFE, sg_exp:32'hFFFFFFF8};
        vecs[2] = '{d3:4'h0, d2:4'h0, d1:4'h5, d0:4'h0, dp:4'b0000, lz:1'b1,
                    an_exp:16'hFFDE, sg_exp:32'hFFFF92C0};
        vecs[3] = '{d3:4'hA, d2:4'hB, d1:4'hC, d0:4'hD, dp:4'b0101, lz:1'b0,
                    an_exp:16'h7BDE, sg_exp:32'h8803C621};
        vecs[4] = '{d3:4'h0, d2:4'h9, d1:4'h0, d0:4'h0, dp:4'b1111, lz:1'b1,
                    an_exp:16'hFBDE, sg_exp:32'hFF104040};
        vecs[5] = '{d3:4'hE, d2:4'hF, d1:4'h6, d0:4'h5, dp:4'b0000, lz:1'b1,
                    an_exp:16'h7BDE, sg_exp:32'h868E8292};

        reset = 1'b1; blink = 1'b0; blank_lz = 1'b0; dp_in = 4'b0000;
        set_digits(4'h0, 4'h0, 4'h0, 4'h0);

        // Reset state and first digit after release
        step(3);
        chk("reset_an", {4'h0, an}, 8'h0F);
        chk("reset_sseg", sseg, 8'hFF);
        chk("reset_frame", {7'd0, frame}, 8'h00);
        reset = 1'b0;
        cyc = 0;
        step(1);
        chk("release_an", {4'h0, an}, 8'h0E);
        chk("release_sseg", sseg, 8'hC0);
        chk("release_frame", {7'd0, frame}, 8'h00);

        // Table vectors: load inputs, wait for the snapshot, check each slot
        for (int i = 0; i < 6; i++) begin
            set_digits(vecs[i].d3, vecs[i].d2, vecs[i].d1, vecs[i].d0);
            dp_in    = vecs[i].dp;
            blank_lz = vecs[i].lz;
            sync_frame();
            step(2);
            for (int s = 0; s < 4; s++) begin
                if (s != 0) step(4);
                exp_an = {4'h0, vecs[i].an_exp[4*s +: 4]};
                exp_sg = vecs[i].sg_exp[8*s +: 8];
                nm = $sformatf("vec%0d_slot%0d_an", i, s);
                chk(nm, {4'h0, an}, exp_an);
                nm = $sformatf("vec%0d_slot%0d_sseg", i, s);
                chk(nm, sseg, exp_sg);
            end
        end

        // Mid-frame input change is hidden until the next snapshot
        blank_lz = 1'b0; dp_in = 4'b0000;
        set_digits(4'h0, 4'h0, 4'h0, 4'h3);
        sync_frame();
        step(2);
        chk("mid_before_sseg", sseg, 8'hB0);
        d0 = 4'h8;
        step(1);
        chk("mid_notear_sseg", sseg, 8'hB0);
        step(11);
        chk("frame_low_q14", {7'd0, frame}, 8'h00);
        step(1);
        chk("frame_high_q15", {7'd0, frame}, 8'h01);
        step(1);
        chk("frame_low_q0", {7'd0, frame}, 8'h00);
        chk("mid_last_slot_sseg", sseg, 8'hC0);
        step(1);
        chk("mid_after_an", {4'h0, an}, 8'h0E);
        chk("mid_after_sseg", sseg, 8'h80);

        // Input changed during the snapshot cycle is captured
        step(14);
        chk("snap_cycle_frame", {7'd0, frame}, 8'h01);
        d0 = 4'h5;
        step(2);
        chk("snap_cycle_sseg", sseg, 8'h92);

        // Blink: lit for 2 frames, dark for 2 frames
        set_digits(4'h0, 4'h0, 4'h0, 4'h1);
        blink = 1'b1;
        sync_frame();
        step(2);
        for (int f = 0; f < 8; f++) begin
            if (f != 0) step(16);
            if ((((cyc - 1) / 16) % 4) >= 2) begin
                exp_an = 8'h0F; exp_sg = 8'hFF;
            end else begin
                exp_an = 8'h0E; exp_sg = 8'hF9;
            end
            nm = $sformatf("blink_f%0d_an", f);
            chk(nm, {4'h0, an}, exp_an);
            nm = $sformatf("blink_f%0d_sseg", f);
            chk(nm, sseg, exp_sg);
        end
        for (int k = 0; k < 4 && ((((cyc - 1) / 16) % 4) < 2); k++) step(16);
        chk("blink_dark_an", {4'h0, an}, 8'h0F);
        blink = 1'b0;
        step(1);
        chk("blink_off_an", {4'h0, an}, 8'h0E);
        chk("blink_off_sseg", sseg, 8'hF9);

        // Reset mid-frame clears the shadow dp
        dp_in = 4'b0001;
        sync_frame();
        step(2);
        chk("dp_lit_sseg", sseg, 8'h79);
        step(4);
        reset = 1'b1;
        step(1);
        chk("midrst_an", {4'h0, an}, 8'h0F);
        chk("midrst_sseg", sseg, 8'hFF);
        chk("midrst_frame", {7'd0, frame}, 8'h00);
        reset = 1'b0;
        cyc = 0;
        step(1);
        chk("postrst_an", {4'h0, an}, 8'h0E);
        chk("postrst_sseg", sseg, 8'hC0);
        step(16);
        chk("postrst_snap_sseg", sseg, 8'h79);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
